// File: rtl/inpref_feeder_if.sv
// Loader write port and PE-side stream port of the input prefetch feeder.
// The feeder takes the slave side, the loader/PE array the master side.
interface inpref_feeder_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_tag;
    logic              pass_done;

    modport master (
        output wr_valid, wr_data,
        input  wr_ready, out_valid, out_data, out_tag, pass_done
    );

    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, out_valid, out_data, out_tag, pass_done
    );
endinterface

// File: rtl/inpref_feeder.sv
// Input prefetch feeder: buffers one input row, then replays it to the PE array
// once per pass with the stride/cut offset chosen by the phase controller.
module inpref_feeder #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int OUT_NUM = 6,
    parameter int CUT_OFS = 1
) (
    input  logic                clk,
    input  logic                fsm_rst_n,
    inpref_feeder_if.slave      bus,
    input  logic                flush,
    input  logic                in_en,
    input  logic                pe_rst,
    input  logic [1:0]          mode_sel,
    input  logic [2:0]          mode_out,
    output logic [1:0]          err
);
    localparam int AW = $clog2(DEPTH);
    // one spare bit so an index stepping past the row end stays visible
    localparam int IW = AW + 1;
    localparam int CW = $clog2(OUT_NUM + 1);

    typedef enum logic [2:0] {EMPTY, FILL, FULL, STREAM, HOLD} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
    logic [IW-1:0]     rd_idx, rd_idx_nxt, idx_p0;
    logic [CW-1:0]     out_cnt, out_cnt_nxt, cnt_p0;
    logic              stride2, stride2_nxt, stride2_p0;
    logic [2:0]        tag_nxt;
    logic [1:0]        err_nxt;
    logic              vld_p0, done_p0;
    logic              wr_fire, pass_start, active;

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        rd_idx_nxt  = rd_idx;
        out_cnt_nxt = out_cnt;
        stride2_nxt = stride2;
        tag_nxt     = bus.out_tag;
        err_nxt     = err;
        vld_p0      = 1'b0;
        done_p0     = 1'b0;

        wr_fire    = bus.wr_valid & bus.wr_ready & ~flush;
        pass_start = (state == FULL) & in_en & pe_rst & ~flush;
        // a starting pass uses the freshly selected mode in its first cycle
        idx_p0     = pass_start ? (mode_sel[1] ? IW'(CUT_OFS) : '0) : rd_idx;
        cnt_p0     = pass_start ? '0 : out_cnt;
        stride2_p0 = pass_start ? ~mode_sel[0] : stride2;
        active     = pass_start |
                     (((state == STREAM) | (state == HOLD)) & in_en & pe_rst & ~flush);

        if (flush) begin
            state_nxt   = EMPTY;
            wr_ptr_nxt  = '0;
            rd_idx_nxt  = '0;
            out_cnt_nxt = '0;
            err_nxt     = '0;
        end else begin
            case (state)
                EMPTY, FILL: begin
                    if (in_en && pe_rst) err_nxt[0] = 1'b1;
                    if (wr_fire) begin
                        wr_ptr_nxt = wr_ptr + AW'(1);
                        state_nxt  = (wr_ptr == AW'(DEPTH - 1)) ? FULL : FILL;
                    end
                end
                FULL: begin
                    if (pass_start) begin
                        state_nxt   = STREAM;
                        stride2_nxt = stride2_p0;
                        tag_nxt     = mode_out;
                        rd_idx_nxt  = idx_p0;
                        out_cnt_nxt = cnt_p0;
                    end
                end
                STREAM, HOLD: begin
                    if (!pe_rst) begin
                        state_nxt   = FULL;
                        rd_idx_nxt  = '0;
                        out_cnt_nxt = '0;
                    end else begin
                        state_nxt = in_en ? STREAM : HOLD;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end

        if (active && (cnt_p0 < CW'(OUT_NUM))) begin
            if (idx_p0 > IW'(DEPTH - 1)) begin
                err_nxt[1] = 1'b1;
            end else begin
                vld_p0      = 1'b1;
                done_p0     = (cnt_p0 == CW'(OUT_NUM - 1));
                rd_idx_nxt  = idx_p0 + (stride2_p0 ? IW'(2) : IW'(1));
                out_cnt_nxt = cnt_p0 + CW'(1);
            end
        end
    end

    // stage p0 -> registered outputs
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state         <= EMPTY;
            wr_ptr        <= '0;
            rd_idx        <= '0;
            out_cnt       <= '0;
            stride2       <= 1'b0;
            err           <= '0;
            bus.wr_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            bus.pass_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_ptr        <= wr_ptr_nxt;
            rd_idx        <= rd_idx_nxt;
            out_cnt       <= out_cnt_nxt;
            stride2       <= stride2_nxt;
            err           <= err_nxt;
            bus.wr_ready  <= (state_nxt == EMPTY) | (state_nxt == FILL);
            bus.out_valid <= vld_p0;
            bus.out_tag   <= tag_nxt;
            bus.pass_done <= done_p0;
            if (vld_p0) bus.out_data <= mem[idx_p0[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_inpref_feeder.sv
// Directed bench: a 16-entry and an 8-entry feeder share one loader and controller.
module tb_inpref_feeder;
    logic       clk = 1'b0;
    logic       fsm_rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       in_en = 1'b0;
    logic       pe_rst = 1'b1;
    logic [1:0] mode_sel = '0;
    logic [2:0] mode_out = '0;
    logic [1:0] err_a, err_b;
    int         checks = 0;
    int         errors = 0;

    inpref_feeder_if #(.DATA_W(8)) ifa ();
    inpref_feeder_if #(.DATA_W(8)) ifb ();

    assign ifa.wr_valid = wr_valid;
    assign ifa.wr_data  = wr_data;
    assign ifb.wr_valid = wr_valid;
    assign ifb.wr_data  = wr_data;

    inpref_feeder #(.DATA_W(8), .DEPTH(16), .OUT_NUM(6), .CUT_OFS(1)) dut_a (
        .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(ifa.slave), .flush(flush), .in_en(in_en),
        .pe_rst(pe_rst), .mode_sel(mode_sel), .mode_out(mode_out), .err(err_a));

    inpref_feeder #(.DATA_W(8), .DEPTH(8), .OUT_NUM(6), .CUT_OFS(1)) dut_b (
        .clk(clk), .fsm_rst_n(fsm_rst_n), .bus(ifb.slave), .flush(flush), .in_en(in_en),
        .pe_rst(pe_rst), .mode_sel(mode_sel), .mode_out(mode_out), .err(err_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_pe_rst();
        in_en  = 1'b0;
        pe_rst = 1'b0;
        tick();
        pe_rst = 1'b1;
    endtask

    task automatic step(input string tag, input logic en, input logic ev, input int ed,
                        input logic edone);
        in_en = en;
        tick();
        check({tag, "_vld"}, ifa.out_valid, ev);
        if (ev) check({tag, "_data"}, ifa.out_data, ed);
        check({tag, "_done"}, ifa.pass_done, edone);
    endtask

    int exp_t2 [6] = '{1, 3, 5, 7, 9, 11};
    int en_t3  [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    int dat_t3 [8] = '{0, 2, 4, 0, 0, 6, 8, 10};

    initial begin
        #12;
        check("rst_wr_ready", ifa.wr_ready, 1'b0);
        check("rst_out_valid", ifa.out_valid, 1'b0);
        check("rst_err", err_a, 2'b00);
        check("rst_tag", ifa.out_tag, 3'b000);
        fsm_rst_n = 1'b1;
        tick();
        check("post_rst_wr_ready", ifa.wr_ready, 1'b1);

        // Test 1: stride 1, no cut
        load(16);
        check("full_wr_ready_a", ifa.wr_ready, 1'b0);
        check("full_wr_ready_b", ifb.wr_ready, 1'b0);
        mode_sel = 2'b01;
        mode_out = 3'b000;
        for (int k = 0; k < 6; k++) step("t1", 1'b1, 1'b1, k, k == 5);
        check("t1_tag", ifa.out_tag, 3'b000);
        step("t1_pause", 1'b0, 1'b0, 0, 1'b0);
        step("t1_after", 1'b1, 1'b0, 0, 1'b0);
        check("t1_after_err", err_a, 2'b00);

        // Test 4: rewind, cut + stride 1 from retained buffer
        pulse_pe_rst();
        check("t4_wr_ready", ifa.wr_ready, 1'b0);
        mode_sel = 2'b11;
        mode_out = 3'b011;
        for (int k = 0; k < 6; k++) step("t4", 1'b1, 1'b1, k + 1, k == 5);
        check("t4_tag", ifa.out_tag, 3'b011);

        // Tests 2 and 5: cut + stride 2; the 8-deep feeder overruns
        pulse_pe_rst();
        mode_sel = 2'b10;
        mode_out = 3'b100;
        for (int k = 0; k < 6; k++) begin
            step("t2", 1'b1, 1'b1, exp_t2[k], k == 5);
            check("t5_vld", ifb.out_valid, k < 4);
            if (k < 4) check("t5_data", ifb.out_data, exp_t2[k]);
            check("t5_done", ifb.pass_done, 1'b0);
            check("t5_err", err_b[1], k >= 4);
        end
        check("t2_tag", ifa.out_tag, 3'b100);

        // Test 3: stride 2 with a two-cycle pause
        pulse_pe_rst();
        mode_sel = 2'b00;
        for (int k = 0; k < 8; k++)
            step("t3", en_t3[k] != 0, en_t3[k] != 0, dat_t3[k], k == 7);

        // in_en together with pe_rst low: rewind wins, nothing emitted
        in_en  = 1'b1;
        pe_rst = 1'b0;
        tick();
        check("rst_vs_en_vld", ifa.out_valid, 1'b0);
        pe_rst = 1'b1;
        in_en  = 1'b0;

        // Test 6: early in_en during FILL, then flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_wr_ready", ifa.wr_ready, 1'b1);
        check("t6_flush_err_b", err_b, 2'b00);
        load(5);
        step("t6_early", 1'b1, 1'b0, 0, 1'b0);
        check("t6_err0", err_a, 2'b01);
        in_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_err_clr", err_a, 2'b00);
        check("t6_wr_ready", ifa.wr_ready, 1'b1);
        check("t6_vld", ifa.out_valid, 1'b0);
        load(15);
        check("t6_15_wr_ready", ifa.wr_ready, 1'b1);
        load(1);
        check("t6_16_wr_ready", ifa.wr_ready, 1'b0);

        // Test 7: async reset mid-stream; buffer now holds 0..14 then 0
        mode_sel = 2'b01;
        mode_out = 3'b101;
        step("t7", 1'b1, 1'b1, 0, 1'b0);
        step("t7", 1'b1, 1'b1, 1, 1'b0);
        check("t7_tag_pre", ifa.out_tag, 3'b101);
        in_en = 1'b0;
        fsm_rst_n = 1'b0;
        #1;
        check("t7_vld", ifa.out_valid, 1'b0);
        check("t7_data", ifa.out_data, 8'h00);
        check("t7_tag", ifa.out_tag, 3'b000);
        check("t7_wr_ready", ifa.wr_ready, 1'b0);
        #2;
        fsm_rst_n = 1'b1;
        tick();
        check("t7_post_wr_ready", ifa.wr_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
